obstacle_spawner: RTL and testbench

// - Consumes the 64-bit pseudo-random word from the LFSR stage and turns it into

---
 rtl/obstacle_spawner_pkg.sv | 15 +
 rtl/obstacle_slot.sv | 47 ++++
 rtl/obstacle_spawner.sv | 129 ++++++++++++
 tb/tb_obstacle_spawner.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_spawner_pkg.sv
// Shared widths and FSM encoding for the obstacle spawner and its slot registers.
package obstacle_spawner_pkg;
  localparam int X_W      = 11;
  localparam int Y_W      = 10;
  localparam int TYPE_W   = 2;
  localparam int CNT_W    = 8;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SPAWN = 2'd2
  } state_t;
endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: loads at the right edge, scrolls left, drops itself off-screen.
module obstacle_slot
  import obstacle_spawner_pkg::*;
#(
  parameter int SPAWN_X      = 640,
  parameter int SCROLL_SPEED = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [Y_W-1:0]    new_y,
  input  logic [TYPE_W-1:0] new_type,
  input  logic              scroll,
  input  logic              clear,
  output logic              valid,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [TYPE_W-1:0] kind
);

  localparam logic [X_W-1:0] SPAWN_X_V = X_W'(SPAWN_X);
  localparam logic [X_W-1:0] SPEED_V   = X_W'(SCROLL_SPEED);

  // Load only ever targets a free slot, so it never competes with scrolling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      x     <= '0;
      y     <= '0;
      kind  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      x     <= '0;
      y     <= '0;
      kind  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      x     <= SPAWN_X_V;
      y     <= new_y;
      kind  <= new_type;
    end else if (scroll && valid) begin
      if (x < SPEED_V) valid <= 1'b0;
      else             x     <= x - SPEED_V;
    end
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Turns LFSR words into obstacle spawns, scrolls the slot table once per frame.
module obstacle_spawner
  import obstacle_spawner_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int SPAWN_X      = 640,
  parameter int SCROLL_SPEED = 4,
  parameter int Y_MIN        = 40,
  parameter int Y_RANGE      = 400,
  parameter int GAP_MIN      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [63:0]                 rand_word,
  input  logic                        frame_tick,
  input  logic                        game_active,
  output logic [NUM_SLOTS-1:0]        slot_valid,
  output logic [NUM_SLOTS*X_W-1:0]    slot_x,
  output logic [NUM_SLOTS*Y_W-1:0]    slot_y,
  output logic [NUM_SLOTS*TYPE_W-1:0] slot_type,
  output logic                        spawn_pulse,
  output logic                        overflow,
  output logic [1:0]                  dbg_state
);

  localparam logic [Y_W-1:0]   Y_MIN_V   = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0]   Y_RANGE_V = Y_W'(Y_RANGE);
  localparam logic [CNT_W-1:0] GAP_V     = CNT_W'(GAP_MIN);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 spawn_now, clear_all, ovf_clr, scroll;
  logic                 any_free;
  logic [NUM_SLOTS-1:0] free_sel, load_vec;
  logic [Y_W-1:0]       raw, y_off, spawn_y;
  logic                 unused_rand;

  assign unused_rand = ^{rand_word[63:18], rand_word[9]};
  assign dbg_state   = state_q;

  // Raw is below 2*Y_RANGE, so one conditional subtract folds it into the band.
  assign raw     = {1'b0, rand_word[8:0]};
  assign y_off   = (raw >= Y_RANGE_V) ? raw - Y_RANGE_V : raw;
  assign spawn_y = Y_MIN_V + y_off;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    spawn_now = 1'b0;
    clear_all = 1'b0;
    ovf_clr   = 1'b0;
    scroll    = 1'b0;
    if (!game_active) begin
      state_d   = IDLE;
      clear_all = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT;
          cnt_d   = GAP_V;
          ovf_clr = 1'b1;
        end
        WAIT: begin
          scroll = frame_tick;
          if (frame_tick) begin
            if (cnt_q <= CNT_W'(1)) state_d = SPAWN;
            else                    cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        SPAWN: begin
          scroll    = frame_tick;
          spawn_now = 1'b1;
          state_d   = WAIT;
          cnt_d     = GAP_V + CNT_W'(rand_word[15:10]);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Eligibility uses the pre-tick valid flags, so a slot freed this cycle waits.
  always_comb begin
    free_sel = '0;
    any_free = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_valid[i] && !any_free) begin
        free_sel[i] = 1'b1;
        any_free    = 1'b1;
      end
    end
  end

  assign load_vec = free_sel & {NUM_SLOTS{spawn_now}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= GAP_V;
      spawn_pulse <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      spawn_pulse <= spawn_now & any_free;
      if (ovf_clr)                    overflow <= 1'b0;
      else if (spawn_now && !any_free) overflow <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    obstacle_slot #(
      .SPAWN_X      (SPAWN_X),
      .SCROLL_SPEED (SCROLL_SPEED)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load_vec[i]),
      .new_y    (spawn_y),
      .new_type (rand_word[17:16]),
      .scroll   (scroll),
      .clear    (clear_all),
      .valid    (slot_valid[i]),
      .x        (slot_x[X_W*i +: X_W]),
      .y        (slot_y[Y_W*i +: Y_W]),
      .kind     (slot_type[TYPE_W*i +: TYPE_W])
    );
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: frame-level model plus pinned literal checks.
module tb_obstacle_spawner;
  import obstacle_spawner_pkg::*;

  localparam int NS = 4;

  logic          clk;
  logic          rst;
  logic [63:0]   rand_word;
  logic          frame_tick;
  logic          game_active;
  logic [NS-1:0] slot_valid;
  logic [NS*11-1:0] slot_x;
  logic [NS*10-1:0] slot_y;
  logic [NS*2-1:0]  slot_type;
  logic          spawn_pulse;
  logic          overflow;
  logic [1:0]    dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  obstacle_spawner dut (
    .clk         (clk),
    .rst         (rst),
    .rand_word   (rand_word),
    .frame_tick  (frame_tick),
    .game_active (game_active),
    .slot_valid  (slot_valid),
    .slot_x      (slot_x),
    .slot_y      (slot_y),
    .slot_type   (slot_type),
    .spawn_pulse (spawn_pulse),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int get_x(input int i); return int'(slot_x[i*11 +: 11]); endfunction
  function automatic int get_y(input int i); return int'(slot_y[i*10 +: 10]); endfunction
  function automatic int get_t(input int i); return int'(slot_type[i*2 +: 2]); endfunction

  // ---------------- behavioural model ----------------
  // phase: 0 = stopped, 1 = counting frames until a spawn, 2 = spawning this cycle
  int m_phase;
  int m_gap;
  bit m_v [NS];
  int m_x [NS];
  int m_y [NS];
  int m_t [NS];
  bit m_pulse;
  bit m_ovf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0;
      m_gap   = 8;
      m_pulse = 0;
      m_ovf   = 0;
      for (int i = 0; i < NS; i++) begin
        m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; m_t[i] = 0;
      end
    end else begin
      m_pulse = 0;
      if (!game_active) begin
        m_phase = 0;
        for (int i = 0; i < NS; i++) m_v[i] = 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
        m_gap   = 8;
        m_ovf   = 0;
      end else begin
        int free_idx;
        free_idx = -1;
        for (int i = NS - 1; i >= 0; i--) if (!m_v[i]) free_idx = i;
        if (frame_tick) begin
          for (int i = 0; i < NS; i++) begin
            if (m_v[i]) begin
              if (m_x[i] < 4) m_v[i] = 0;
              else            m_x[i] = m_x[i] - 4;
            end
          end
        end
        if (m_phase == 2) begin
          if (free_idx >= 0) begin
            m_v[free_idx] = 1;
            m_x[free_idx] = 640;
            m_y[free_idx] = 40 + (int'(rand_word[8:0]) % 400);
            m_t[free_idx] = int'(rand_word[17:16]);
            m_pulse = 1;
          end else begin
            m_ovf = 1;
          end
          m_gap   = 8 + int'(rand_word[15:10]);
          m_phase = 1;
        end else if (frame_tick) begin
          if (m_gap <= 1) m_phase = 2;
          else            m_gap   = m_gap - 1;
        end
      end
    end
  end

  // ---------------- scoreboard: every cycle out of reset ----------------
  always @(negedge clk) begin
    if (rst) begin
      logic [NS-1:0] ev;
      for (int i = 0; i < NS; i++) ev[i] = m_v[i];
      chk("model_valid", slot_valid, ev);
      chk("model_pulse", spawn_pulse, m_pulse);
      chk("model_overflow", overflow, m_ovf);
      for (int i = 0; i < NS; i++) begin
        if (m_v[i])
          chk($sformatf("model_slot%0d_xyt", i),
              (get_x(i) << 12) | (get_y(i) << 2) | get_t(i),
              (m_x[i] << 12) | (m_y[i] << 2) | m_t[i]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_half();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic tick();
    tick_half();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // tick in two consecutive cycles so the second lands in the spawn cycle
  task automatic tick_pair();
    frame_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0; game_active = 1'b0; frame_tick = 1'b0; rand_word = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", slot_valid, 0);
    chk("reset_x", slot_x, 0);
    chk("reset_pulse", spawn_pulse, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_state", dbg_state, IDLE);

    // spawn decode
    rst = 1'b1; game_active = 1'b1;
    @(negedge clk);
    chk("start_state", dbg_state, WAIT);
    rand_word = 64'h0000_0000_0002_15F4;
    ticks(7);
    chk("gap7_no_slot", slot_valid, 0);
    tick();
    chk("spawn1_pulse", spawn_pulse, 1);
    chk("spawn1_valid", slot_valid, 4'b0001);
    chk("spawn1_x", get_x(0), 640);
    chk("spawn1_y", get_y(0), 140);
    chk("spawn1_type", get_t(0), 2);
    rand_word = 64'h0000_0000_0001_00C8;
    ticks(12);
    chk("gap12_one_slot", slot_valid, 4'b0001);
    tick();
    chk("spawn2_valid", slot_valid, 4'b0011);
    chk("spawn2_x0", get_x(0), 588);
    chk("spawn2_x1", get_x(1), 640);
    chk("spawn2_y1", get_y(1), 240);
    chk("spawn2_type1", get_t(1), 1);

    // fill the table, band edges raw=399 and raw=400
    rand_word = 64'h0000_0000_0000_018F;
    ticks(8);
    chk("spawn3_y_top", get_y(2), 439);
    rand_word = 64'h0000_0000_0003_0190;
    ticks(8);
    chk("spawn4_y_wrap", get_y(3), 40);
    chk("spawn4_type", get_t(3), 3);
    chk("full_valid", slot_valid, 4'b1111);
    rand_word = 64'h0;
    ticks(8);
    chk("full_no_pulse", spawn_pulse, 0);
    chk("full_overflow", overflow, 1);
    chk("full_x1", get_x(1), 544);

    // stop / start
    game_active = 1'b0;
    @(negedge clk);
    chk("stop_valid", slot_valid, 0);
    chk("stop_state", dbg_state, IDLE);
    chk("stop_overflow_held", overflow, 1);
    game_active = 1'b1;
    @(negedge clk);
    chk("restart_overflow", overflow, 0);
    chk("restart_state", dbg_state, WAIT);
    ticks(7);
    chk("restart_gap7", slot_valid, 0);
    tick();
    chk("restart_spawn", slot_valid, 4'b0001);

    // tick in the spawn cycle
    ticks(7);
    tick_pair();
    chk("simul_pulse", spawn_pulse, 1);
    chk("simul_x0", get_x(0), 604);
    chk("simul_x1", get_x(1), 640);

    // asynchronous reset mid-run with three slots valid
    ticks(8);
    chk("three_valid", slot_valid, 4'b0111);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", slot_valid, 0);
    chk("async_x", slot_x, 0);
    chk("async_state", dbg_state, IDLE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ticks(7);
    chk("post_reset_gap7", slot_valid, 0);
    tick();
    chk("post_reset_spawn", slot_valid, 4'b0001);
    chk("post_reset_x", get_x(0), 640);

    // expiry of slot 0
    ticks(159);
    tick_half();
    chk("expiry160_valid", slot_valid[0], 1);
    chk("expiry160_x", get_x(0), 0);
    @(negedge clk);
    tick_half();
    chk("expiry161_valid", slot_valid[0], 0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
